// File: rtl/reg_scoreboard_pkg.sv
// Shared constants for the register scoreboard: register-file geometry
// and the hard-wired zero register address.
`ifndef REG_SCOREBOARD_PKG_SV
`define REG_SCOREBOARD_PKG_SV

package reg_scoreboard_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

endpackage

`endif

// File: rtl/pending_counter.sv
// One saturating up/down counter of outstanding writes for a single register.
// Simultaneous inc and dec cancel; illegal moves are flagged, never taken.
module pending_counter #(
    parameter int CNT_W = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic dec,
    output logic zero,
    output logic max,
    output logic underflow,
    output logic overflow
);

    logic [CNT_W-1:0] cnt;

    assign zero      = (cnt == '0);
    assign max       = (cnt == '1);
    assign underflow = dec && !inc && zero;
    assign overflow  = inc && !dec && max;

    // Saturate at both ends; the error flags report the blocked move.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc && !dec && !max) begin
            cnt <= cnt + CNT_W'(1);
        end else if (dec && !inc && !zero) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/reg_scoreboard.sv
// Tracks outstanding register-file writes between decode and write-back
// and raises stall when decode depends on, or would overflow, a pending write.
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int CNT_W = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    input  logic                  issue_we,
    input  logic [REG_ADDR_W-1:0] issue_dest,
    input  logic                  use_rs,
    input  logic [REG_ADDR_W-1:0] rs_addr,
    input  logic                  use_rt,
    input  logic [REG_ADDR_W-1:0] rt_addr,
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] wb_dest,
    output logic                  stall,
    output logic [NUM_REGS-1:0]   busy,
    output logic                  err
);

    logic [NUM_REGS-1:1] inc_vec, dec_vec, zero_vec, max_bits, under_vec, over_vec;
    logic [NUM_REGS-1:0] busy_vec, max_vec;
    logic hazard, full, accept;

    // Register $0 is never tracked, so its slot is tied off to idle.
    assign busy_vec = {~zero_vec, 1'b0};
    assign max_vec  = {max_bits, 1'b0};
    assign busy     = busy_vec;

    always_comb begin
        hazard = 1'b0;
        full   = 1'b0;
        if (use_rs && rs_addr != REG_ZERO && busy_vec[rs_addr]) hazard = 1'b1;
        if (use_rt && rt_addr != REG_ZERO && busy_vec[rt_addr]) hazard = 1'b1;
        if (issue_we && issue_dest != REG_ZERO && max_vec[issue_dest]) full = 1'b1;
    end

    assign stall  = issue_valid && (hazard || full);
    assign accept = issue_valid && !stall;

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            inc_vec[i] = accept && issue_we && (issue_dest == REG_ADDR_W'(i));
            dec_vec[i] = wb_valid && (wb_dest == REG_ADDR_W'(i));
        end
    end

    for (genvar g = 1; g < NUM_REGS; g++) begin : g_cnt
        pending_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk       (clk),
            .rst       (rst),
            .inc       (inc_vec[g]),
            .dec       (dec_vec[g]),
            .zero      (zero_vec[g]),
            .max       (max_bits[g]),
            .underflow (under_vec[g]),
            .overflow  (over_vec[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if ((|under_vec) || (|over_vec)) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed scenarios with literal
// expectations, then randomized traffic against a per-register count model.
module tb_reg_scoreboard;

    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic        clk = 1'b0;
    logic        rst, issue_valid, issue_we, use_rs, use_rt, wb_valid;
    logic [4:0]  issue_dest, rs_addr, rt_addr, wb_dest;
    logic        stall, err;
    logic [31:0] busy;

    int total = 0;
    int bad   = 0;
    int mcnt[32];
    bit merr = 1'b0;
    bit exp_stall;
    bit sampled_stall;

    reg_scoreboard #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_we(issue_we), .issue_dest(issue_dest),
        .use_rs(use_rs), .rs_addr(rs_addr), .use_rt(use_rt), .rt_addr(rt_addr),
        .wb_valid(wb_valid), .wb_dest(wb_dest),
        .stall(stall), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_busy();
        logic [31:0] b = '0;
        for (int i = 1; i < 32; i++) b[i] = (mcnt[i] != 0);
        return b;
    endfunction

    function automatic bit model_stall();
        bit h, f;
        h = (use_rs && rs_addr != 0 && mcnt[rs_addr] != 0) ||
            (use_rt && rt_addr != 0 && mcnt[rt_addr] != 0);
        f = issue_we && issue_dest != 0 && mcnt[issue_dest] == CNT_MAX;
        return issue_valid && (h || f);
    endfunction

    // Drives one cycle, checks stall before the edge and state after it.
    task automatic applyStimulus(input bit iv, input bit we, input logic [4:0] dest,
                                 input bit urs, input logic [4:0] rs,
                                 input bit urt, input logic [4:0] rt,
                                 input bit wbv, input logic [4:0] wbd, input bit r);
        int inc_r, dec_r;
        @(negedge clk);
        issue_valid = iv; issue_we = we; issue_dest = dest;
        use_rs = urs; rs_addr = rs; use_rt = urt; rt_addr = rt;
        wb_valid = wbv; wb_dest = wbd; rst = r;
        #2;
        exp_stall = model_stall();
        sampled_stall = stall;
        checkOutput("stall", {31'b0, stall}, {31'b0, exp_stall});
        @(posedge clk);
        if (r) begin
            foreach (mcnt[i]) mcnt[i] = 0;
            merr = 1'b0;
        end else begin
            inc_r = (iv && !exp_stall && we && dest != 0) ? int'(dest) : -1;
            dec_r = (wbv && wbd != 0) ? int'(wbd) : -1;
            if (!(inc_r == dec_r && inc_r > 0)) begin
                if (inc_r > 0) begin
                    if (mcnt[inc_r] == CNT_MAX) merr = 1'b1; else mcnt[inc_r]++;
                end
                if (dec_r > 0) begin
                    if (mcnt[dec_r] == 0) merr = 1'b1; else mcnt[dec_r]--;
                end
            end
        end
        #1;
        checkOutput("busy", busy, model_busy());
        checkOutput("err", {31'b0, err}, {31'b0, merr});
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int q[$];
        int pick;
        foreach (mcnt[i]) mcnt[i] = 0;
        rst = 0; issue_valid = 0; issue_we = 0; issue_dest = 0;
        use_rs = 0; rs_addr = 0; use_rt = 0; rt_addr = 0; wb_valid = 0; wb_dest = 0;

        // Reset then idle
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("rst_busy", busy, 32'h0);
        checkOutput("rst_err", {31'b0, err}, 32'h0);
        idle();
        checkOutput("idle_stall", {31'b0, sampled_stall}, 32'h0);

        // RAW on $8 released one cycle after write-back
        applyStimulus(1, 1, 8, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("r8_busy", busy, 32'h0000_0100);
        applyStimulus(1, 0, 0, 1, 8, 0, 0, 0, 0, 0);
        checkOutput("r8_stall", {31'b0, sampled_stall}, 32'h1);
        applyStimulus(1, 0, 0, 1, 8, 0, 0, 1, 8, 0);
        checkOutput("r8_wb_stall", {31'b0, sampled_stall}, 32'h1);
        checkOutput("r8_wb_busy", busy, 32'h0);
        applyStimulus(1, 0, 0, 1, 8, 0, 0, 0, 0, 0);
        checkOutput("r8_release", {31'b0, sampled_stall}, 32'h0);

        // Capacity on $3
        repeat (3) applyStimulus(1, 1, 3, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("r3_busy", busy, 32'h0000_0008);
        applyStimulus(1, 1, 3, 0, 0, 0, 0, 1, 3, 0);
        checkOutput("r3_full", {31'b0, sampled_stall}, 32'h1);
        applyStimulus(1, 1, 3, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("r3_accept", {31'b0, sampled_stall}, 32'h0);
        repeat (3) applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 3, 0);
        checkOutput("r3_drain", busy, 32'h0);

        // Simultaneous issue and retire on $5
        applyStimulus(1, 1, 5, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 5, 0, 0, 0, 0, 1, 5, 0);
        checkOutput("r5_busy", busy, 32'h0000_0020);
        checkOutput("r5_err", {31'b0, err}, 32'h0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 5, 0);

        // Register $0 ignored
        applyStimulus(1, 1, 0, 1, 0, 1, 0, 1, 0, 0);
        checkOutput("r0_stall", {31'b0, sampled_stall}, 32'h0);
        checkOutput("r0_busy", busy, 32'h0);
        checkOutput("r0_err", {31'b0, err}, 32'h0);

        // Sticky underflow error, then mid-operation reset
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 12, 0);
        checkOutput("uf_err", {31'b0, err}, 32'h1);
        applyStimulus(1, 1, 7, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 7, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("uf_sticky", {31'b0, err}, 32'h1);
        checkOutput("r7_busy", busy, 32'h0000_0080);
        applyStimulus(1, 1, 9, 1, 7, 0, 0, 1, 7, 1);
        checkOutput("rst_cycle_stall", {31'b0, sampled_stall}, 32'h1);
        checkOutput("rst_mid_busy", busy, 32'h0);
        checkOutput("rst_mid_err", {31'b0, err}, 32'h0);

        // Randomized traffic on a small register window
        for (int n = 0; n < 3000; n++) begin
            q.delete();
            for (int i = 1; i < 8; i++) if (mcnt[i] != 0) q.push_back(i);
            if (q.size() != 0 && $urandom_range(9) != 0)
                pick = q[$urandom_range(q.size() - 1)];
            else
                pick = $urandom_range(7);
            applyStimulus($urandom_range(3) != 0, $urandom_range(2) != 0, 5'($urandom_range(7)),
                          $urandom_range(1) == 1, 5'($urandom_range(7)),
                          $urandom_range(1) == 1, 5'($urandom_range(7)),
                          $urandom_range(2) == 0, 5'(pick),
                          $urandom_range(99) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
